muldiv_sequencer: RTL

Multi-cycle multiply/divide unit that replaces the single-cycle behavioural multiplier and divider feeding the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU requests from the Control unit and runs a radix-2 shift-add or restoring-divide iteration, one bit per cycle. While it works it holds busy high so Control can stall pc_clk. On completion it pulses the HI/LO write enables with the 64-bit result.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Optional build macro (used by the top): MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LAT_FIXED = 34;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  // Bit 1 of the opcode selects divide, bit 0 selects signed arithmetic.
  function automatic logic op_is_div(input logic [1:0] op_code);
    return op_code[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op_code);
    return op_code[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
// Purely combinational; the sequencer owns every register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic [WIDTH-1:0]   shift,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   shift_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_new;

  // Multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = operand[gi] & shift[0];
    end
  endgenerate

  // Multiply: add into the upper half, then shift the whole accumulator right
  // with the carry entering at the top.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Divide: remainder:quotient shifted left, then trial subtract.
  assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
  assign trial     = rem_shift - {1'b0, operand};
  assign trial_ok  = ~trial[WIDTH];
  assign rem_new   = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];

  always_comb begin
    if (div_mode) begin
      acc_next   = {rem_new, acc[WIDTH-2:0], trial_ok};
      shift_next = shift;
    end else begin
      acc_next   = {mul_sum, acc[WIDTH-1:1]};
      shift_next = shift >> 1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit feeding HI/LO, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the multiplier runs out.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_w,
  output logic             lo_w,
  output logic             dz
);

  state_e               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [WIDTH-1:0]     operand_reg, operand_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic                 div_reg, div_next;
  logic                 neg_q_reg, neg_q_next;
  logic                 neg_r_reg, neg_r_next;
  logic                 dz_reg, dz_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]     step_shift;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic [2*WIDTH-1:0]   prod_fix;

  assign abs_a = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
  assign abs_b = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_reg),
    .operand    (operand_reg),
    .shift      (mplier_reg),
    .div_mode   (div_reg),
    .acc_next   (step_acc),
    .shift_next (step_shift)
  );

  // Sign correction; the negate flags are only ever set for signed ops.
  assign quot_fix = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      operand_reg <= '0;
      mplier_reg  <= '0;
      div_reg     <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dz_reg      <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      mplier_reg  <= mplier_next;
      div_reg     <= div_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      dz_reg      <= dz_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    mplier_next  = mplier_reg;
    div_next     = div_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    dz_next      = dz_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;

    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          div_next     = op_is_div(op);
          neg_q_next   = op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_next   = op_is_signed(op) & a[WIDTH-1];
          operand_next = op_is_div(op) ? abs_b : abs_a;
          mplier_next  = abs_b;
          cnt_next     = '0;
          dz_next      = 1'b0;
          if (op_is_div(op) && (b == '0)) begin
            acc_next   = {a, {WIDTH{1'b1}}};
            dz_next    = 1'b1;
            state_next = DONE;
          end else begin
            acc_next   = op_is_div(op) ? {{WIDTH{1'b0}}, abs_a} : '0;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        acc_next    = step_acc;
        mplier_next = step_shift;
        cnt_next    = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          cnt_next   = '0;
          state_next = FIX;
        end
`ifdef MULDIV_EARLY_OUT_EN
        // No multiplier bits left: apply all remaining right shifts at once.
        else if (!div_reg && (step_shift == '0)) begin
          acc_next   = step_acc >> (CNT_W'(WIDTH - 1) - cnt_reg);
          cnt_next   = '0;
          state_next = FIX;
        end
`endif
      end

      FIX: begin
        acc_next   = div_reg ? {rem_fix, quot_fix} : prod_fix;
        state_next = DONE;
      end

      DONE: begin
        hi_next    = acc_reg[2*WIDTH-1:WIDTH];
        lo_next    = acc_reg[WIDTH-1:0];
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Abort also cancels the HI/LO update of a DONE cycle.
    if (flush && (state_reg != IDLE)) begin
      state_next = IDLE;
      cnt_next   = '0;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE) && !flush;
  assign hi_w = done;
  assign lo_w = done;
  assign dz   = done & dz_reg;
  assign hi   = done ? acc_reg[2*WIDTH-1:WIDTH] : hi_reg;
  assign lo   = done ? acc_reg[WIDTH-1:0] : lo_reg;

endmodule
